// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and pipe_hazard_ctrl (slave).
// mc_wait_dbg mirrors the multi-cycle FSM state so checkers can bind to it.
interface pipe_hazard_ctrl_if #(
    parameter int FWD_DEPTH = 2
);
    logic [4:0]             rs_addr;
    logic [4:0]             rt_addr;
    logic                   rs_used;
    logic                   rt_used;
    logic                   id_is_branch;
    logic [5*FWD_DEPTH-1:0] fwd_addr;
    logic [FWD_DEPTH-1:0]   fwd_wen;
    logic [FWD_DEPTH-1:0]   fwd_is_load;
    logic                   mc_start;
    logic                   mc_done;
    logic [2:0]             rs_fwd_sel;
    logic [2:0]             rt_fwd_sel;
    logic [4:0]             stage_en;
    logic [4:0]             stage_rst;
    logic                   mc_timeout;
    logic                   mc_wait_dbg;

    modport master (
        output rs_addr, rt_addr, rs_used, rt_used, id_is_branch,
        output fwd_addr, fwd_wen, fwd_is_load, mc_start, mc_done,
        input  rs_fwd_sel, rt_fwd_sel, stage_en, stage_rst, mc_timeout, mc_wait_dbg
    );

    modport slave (
        input  rs_addr, rt_addr, rs_used, rt_used, id_is_branch,
        input  fwd_addr, fwd_wen, fwd_is_load, mc_start, mc_done,
        output rs_fwd_sel, rt_fwd_sel, stage_en, stage_rst, mc_timeout, mc_wait_dbg
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: operand forwarding, load-use stall, multi-cycle hold
// with timeout, and branch flush. Optional debug hold/step enabled by macro HAZARD_DEBUG_EN.
module pipe_hazard_ctrl #(
    parameter int FWD_DEPTH      = 2,
    parameter int LOAD_READY     = 2,
    parameter int BRANCH_PENALTY = 3,
    parameter int MC_TIMEOUT     = 64
) (
    input  logic clk,
    input  logic rst,
`ifdef HAZARD_DEBUG_EN
    input  logic debug_en,
    input  logic debug_step,
`endif
    pipe_hazard_ctrl_if.slave bus
);

    localparam int         CW       = $clog2(MC_TIMEOUT + 1);
    localparam logic [2:0] BRC_LOAD = 3'(BRANCH_PENALTY - 1);

    typedef enum logic {MC_IDLE, MC_WAIT} mc_state_e;

    mc_state_e       mc_state_q, mc_state_d;
    logic [CW-1:0]   mc_cnt_q, mc_cnt_d;
    logic [2:0]      brc_q, brc_d;
    logic            timeout_q, timeout_d;
    logic            mc_hold;
    logic            dbg_hold;
    logic [2:0]      rs_sel, rt_sel;
    logic            load_stall;
    logic [4:0]      en, srst;

    // Nearest producing stage wins, so scan from the oldest down and let younger overwrite.
    function automatic logic [2:0] fwd_pick(input logic [4:0] src, input logic used,
                                            input logic [5*FWD_DEPTH-1:0] addr,
                                            input logic [FWD_DEPTH-1:0] wen);
        logic [2:0] sel;
        sel = 3'd0;
        if (used && src != 5'd0) begin
            for (int k = FWD_DEPTH; k >= 1; k--) begin
                if (wen[k-1] && addr[5*k-1 -: 5] == src) sel = 3'(k);
            end
        end
        return sel;
    endfunction

    function automatic logic load_pending(input logic [2:0] sel,
                                          input logic [FWD_DEPTH-1:0] is_load);
        logic hit;
        hit = 1'b0;
        for (int k = 1; k <= FWD_DEPTH; k++) begin
            if (sel == 3'(k) && k < LOAD_READY && is_load[k-1]) hit = 1'b1;
        end
        return hit;
    endfunction

`ifdef HAZARD_DEBUG_EN
    logic step_q;
    always_ff @(posedge clk) begin
        if (rst) step_q <= 1'b0;
        else     step_q <= debug_step;
    end
    assign dbg_hold = debug_en & ~(debug_step & ~step_q);
`else
    assign dbg_hold = 1'b0;
`endif

    always_comb begin
        logic rs_stall, rt_stall;
        rs_sel     = fwd_pick(bus.rs_addr, bus.rs_used, bus.fwd_addr, bus.fwd_wen);
        rt_sel     = fwd_pick(bus.rt_addr, bus.rt_used, bus.fwd_addr, bus.fwd_wen);
        rs_stall   = load_pending(rs_sel, bus.fwd_is_load);
        rt_stall   = load_pending(rt_sel, bus.fwd_is_load);
        load_stall = rs_stall | rt_stall;
        bus.rs_fwd_sel = rs_stall ? 3'd0 : rs_sel;
        bus.rt_fwd_sel = rt_stall ? 3'd0 : rt_sel;
    end

    always_comb begin
        mc_state_d = mc_state_q;
        mc_cnt_d   = mc_cnt_q;
        brc_d      = brc_q;
        timeout_d  = timeout_q;
        mc_hold    = 1'b0;
        en         = 5'b11111;
        srst       = 5'b00000;
        if (rst) begin
            srst = 5'b11111;
        end else if (dbg_hold) begin
            en = 5'b00000;
        end else begin
            case (mc_state_q)
                MC_IDLE: begin
                    if (bus.mc_start && !bus.mc_done) begin
                        mc_hold    = 1'b1;
                        mc_state_d = MC_WAIT;
                        mc_cnt_d   = '0;
                    end
                end
                MC_WAIT: begin
                    if (bus.mc_done) begin
                        mc_state_d = MC_IDLE;
                    end else if (mc_cnt_q == CW'(MC_TIMEOUT)) begin
                        // Give up: release the pipeline this cycle as if the result had arrived.
                        mc_state_d = MC_IDLE;
                        timeout_d  = 1'b1;
                    end else begin
                        mc_hold  = 1'b1;
                        mc_cnt_d = mc_cnt_q + CW'(1);
                    end
                end
                default: mc_state_d = MC_IDLE;
            endcase

            if (mc_hold) begin
                en[2:0] = 3'b000;
                srst[3] = 1'b1;
            end else if (load_stall) begin
                en[1:0] = 2'b00;
                srst[2] = 1'b1;
            end else if (bus.id_is_branch) begin
                srst[1] = 1'b1;
                brc_d   = BRC_LOAD;
            end else if (brc_q != 3'd0) begin
                srst[1] = 1'b1;
                brc_d   = brc_q - 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mc_state_q <= MC_IDLE;
            mc_cnt_q   <= '0;
            brc_q      <= 3'd0;
            timeout_q  <= 1'b0;
        end else begin
            mc_state_q <= mc_state_d;
            mc_cnt_q   <= mc_cnt_d;
            brc_q      <= brc_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.stage_en    = en;
    assign bus.stage_rst   = srst;
    assign bus.mc_timeout  = timeout_q;
    assign bus.mc_wait_dbg = (mc_state_q == MC_WAIT);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized scoreboard bench for pipe_hazard_ctrl against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

    localparam int FWD_DEPTH      = 2;
    localparam int LOAD_READY     = 2;
    localparam int BRANCH_PENALTY = 3;
    localparam int MC_TIMEOUT     = 8;
    localparam int N_RANDOM       = 800;

    logic clk;
    logic rst;

    pipe_hazard_ctrl_if #(.FWD_DEPTH(FWD_DEPTH)) bus ();

    pipe_hazard_ctrl #(
        .FWD_DEPTH(FWD_DEPTH),
        .LOAD_READY(LOAD_READY),
        .BRANCH_PENALTY(BRANCH_PENALTY),
        .MC_TIMEOUT(MC_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef HAZARD_DEBUG_EN
        .debug_en(1'b0),
        .debug_step(1'b0),
`endif
        .bus(bus.slave)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // stimulus state (applied by tick)
    logic                 t_rst;
    logic [4:0]           t_rs, t_rt;
    logic                 t_ru, t_tu, t_br, t_ms, t_md;
    logic [4:0]           t_faddr [FWD_DEPTH];
    logic [FWD_DEPTH-1:0] t_fwen, t_fload;

    // reference model state
    int m_age;      // consecutive cycles the current multi-cycle op has held the pipe
    int m_flush;    // remaining flush cycles after a branch
    bit m_to;

    // scoreboard
    logic [16:0] exp_q[$];
    int total;
    int bad;

    function automatic void model_fwd(input logic [4:0] src, input bit used,
                                      output int sel, output bit stall);
        sel   = 0;
        stall = 0;
        if (used && src != 5'd0) begin
            for (int k = 1; k <= FWD_DEPTH; k++) begin
                if (t_fwen[k-1] && t_faddr[k-1] == src) begin
                    sel = k;
                    break;
                end
            end
        end
        if (sel > 0 && sel < LOAD_READY && t_fload[sel-1]) begin
            stall = 1;
            sel   = 0;
        end
    endfunction

    task automatic predict();
        int ss, ts;
        bit sst, tst, busy, e_to;
        logic [4:0] en, sr;
        model_fwd(t_rs, t_ru, ss, sst);
        model_fwd(t_rt, t_tu, ts, tst);
        e_to = m_to;
        en   = 5'b11111;
        sr   = 5'b00000;
        if (t_rst) begin
            sr      = 5'b11111;
            m_age   = 0;
            m_flush = 0;
            m_to    = 0;
        end else begin
            busy = (m_age > 0 || t_ms) && !t_md;
            if (busy && m_age == MC_TIMEOUT + 1) begin
                busy = 0;
                m_to = 1;
            end
            if (busy) begin
                en = 5'b11000;
                sr = 5'b01000;
                m_age++;
            end else begin
                m_age = 0;
                if (sst || tst) begin
                    en = 5'b11100;
                    sr = 5'b00100;
                end else if (t_br) begin
                    sr      = 5'b00010;
                    m_flush = BRANCH_PENALTY - 1;
                end else if (m_flush > 0) begin
                    sr = 5'b00010;
                    m_flush--;
                end
            end
        end
        exp_q.push_back({3'(ss), 3'(ts), en, sr, e_to});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        rst              = t_rst;
        bus.rs_addr      = t_rs;
        bus.rt_addr      = t_rt;
        bus.rs_used      = t_ru;
        bus.rt_used      = t_tu;
        bus.id_is_branch = t_br;
        bus.mc_start     = t_ms;
        bus.mc_done      = t_md;
        for (int k = 0; k < FWD_DEPTH; k++) bus.fwd_addr[5*k +: 5] = t_faddr[k];
        bus.fwd_wen      = t_fwen;
        bus.fwd_is_load  = t_fload;
        predict();
    endtask

    task automatic set_idle();
        t_rst = 0; t_rs = 0; t_rt = 0; t_ru = 0; t_tu = 0;
        t_br = 0; t_ms = 0; t_md = 0; t_fwen = '0; t_fload = '0;
        for (int k = 0; k < FWD_DEPTH; k++) t_faddr[k] = 5'd0;
    endtask

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
        end
    endtask

    // monitor: outputs are combinational, one expected entry per driven cycle
    always @(negedge clk) begin
        logic [16:0] e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("rs_fwd_sel", {2'b00, bus.rs_fwd_sel}, {2'b00, e[16:14]});
            check("rt_fwd_sel", {2'b00, bus.rt_fwd_sel}, {2'b00, e[13:11]});
            check("stage_en",   bus.stage_en,  e[10:6]);
            check("stage_rst",  bus.stage_rst, e[5:1]);
            check("mc_timeout", {4'b0000, bus.mc_timeout}, {4'b0000, e[0]});
        end
    end

    initial begin
        total = 0; bad = 0;
        m_age = 0; m_flush = 0; m_to = 0;
        set_idle();
        rst = 1'b1;
        bus.rs_addr = '0; bus.rt_addr = '0; bus.rs_used = 0; bus.rt_used = 0;
        bus.id_is_branch = 0; bus.fwd_addr = '0; bus.fwd_wen = '0; bus.fwd_is_load = '0;
        bus.mc_start = 0; bus.mc_done = 0;

        t_rst = 1; tick(); tick();
        t_rst = 0; tick();

        // forwarding from EXE, then load-use in EXE, then load in MEM
        set_idle(); t_rs = 5; t_ru = 1; t_faddr[0] = 5; t_fwen = 2'b01; tick();
        t_fload = 2'b01; tick();
        t_faddr[0] = 0; t_faddr[1] = 5; t_fwen = 2'b10; t_fload = 2'b10; tick();
        // both stages match: nearest wins; zero address never forwards
        t_faddr[0] = 5; t_fwen = 2'b11; t_fload = 2'b00; t_rt = 0; t_tu = 1; tick();

        // single branch
        set_idle(); t_br = 1; tick();
        t_br = 0; repeat (4) tick();

        // multi-cycle op completing at cycle 5
        t_ms = 1; repeat (5) tick();
        t_md = 1; tick();
        t_ms = 0; t_md = 0; repeat (2) tick();

        // multi-cycle op that never completes
        t_ms = 1; repeat (MC_TIMEOUT + 2) tick();
        t_ms = 0; repeat (2) tick();

        // reset mid-WAIT
        t_ms = 1; repeat (3) tick();
        t_rst = 1; tick();
        t_rst = 0; t_ms = 0; repeat (2) tick();

        // reset mid-flush
        t_br = 1; tick();
        t_br = 0; tick();
        t_rst = 1; tick();
        t_rst = 0; repeat (3) tick();

        for (int i = 0; i < N_RANDOM; i++) begin
            t_rst = ($urandom_range(0, 59) == 0);
            t_rs  = 5'($urandom_range(0, 3));
            t_rt  = 5'($urandom_range(0, 3));
            t_ru  = ($urandom_range(0, 3) != 0);
            t_tu  = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < FWD_DEPTH; k++) begin
                t_faddr[k]  = 5'($urandom_range(0, 3));
                t_fwen[k]   = 1'($urandom_range(0, 1));
                t_fload[k]  = ($urandom_range(0, 3) == 0);
            end
            if (m_age > 0) begin
                t_ms = 1;
                t_md = ($urandom_range(0, 5) == 0);
            end else begin
                t_ms = ($urandom_range(0, 9) == 0);
                t_md = t_ms && ($urandom_range(0, 3) == 0);
            end
            t_br = ($urandom_range(0, 5) == 0);
            tick();
        end

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameters SHALL be: FWD_DEPTH, default 2, number of later stages checked for forwarding (1..4; stage 1=EXE, 2=MEM, ...).
REQ-002 LOAD_READY, default 2, first stage index where load data is forwardable.
REQ-003 BRANCH_PENALTY, default 3, ID flush cycles per accepted jump/branch (1..4).
REQ-004 MC_TIMEOUT, default 64, max multi-cycle wait cycles before error.
REQ-005 Ports SHALL be, one per line (name, direction, width, meaning), one clock, reset synchronous active-high:
clk  in  1  main clock
rst  in  1  synchronous reset, active-high
rs_addr, rt_addr  in  5 each  ID source register addresses
rs_used, rt_used  in  1 each  ID source actually read
id_is_branch  in  1  ID holds jump/branch
fwd_addr  in  5*FWD_DEPTH  dest address of stage k at bits [5k-1:5k-5]
fwd_wen  in  FWD_DEPTH  stage k writes a register
fwd_is_load  in  FWD_DEPTH  stage k result comes from memory
mc_start  in  1  EXE holds a multi-cycle op
mc_done  in  1  multi-cycle unit result ready
rs_fwd_sel, rt_fwd_sel  out  3 each  0=register file, k=stage k
stage_en  out  5  enable, bit0=IF .. bit4=WB
stage_rst  out  5  stage reset/bubble, same bit order
mc_timeout  out  1  sticky multi-cycle timeout error

Function
REQ-006 Forwarding per source: if used, address nonzero, pick smallest k with fwd_wen[k] and address match; none -> sel 0.
REQ-007 If chosen k < LOAD_READY and fwd_is_load[k]: load stall requested, sel forced 0.
REQ-008 Priority, highest first: rst, debug hold, multi-cycle hold, load stall, branch flush.
REQ-009 rst: stage_rst=5'b11111, stage_en=5'b11111.
REQ-010 Multi-cycle FSM states IDLE, WAIT: IDLE->WAIT on mc_start & ~mc_done; WAIT->IDLE on mc_done or timeout.
REQ-011 Hold = (IDLE & mc_start & ~mc_done) | (WAIT & ~mc_done): stage_en[2:0]=0, stage_rst[3]=1 (MEM bubble); mc_done releases same cycle.
REQ-012 WAIT cycle counter reaching MC_TIMEOUT: mc_timeout set (sticky until rst), FSM to IDLE, pipeline released.
REQ-013 Load stall: stage_en[1:0]=0, stage_rst[2]=1 (EXE bubble).
REQ-014 Branch: id_is_branch with no higher-priority condition -> stage_rst[1]=1, counter loaded BRANCH_PENALTY-1.
REQ-015 Counter nonzero -> stage_rst[1]=1, decrement by 1 per unstalled cycle; frozen during hold/stall/debug hold.
REQ-016 New branch while counter nonzero reloads the counter.
REQ-017 All unnamed bits default en=1, rst=0; forwarding outputs combinational, zero latency.

Reset
REQ-018 On rst: FSM IDLE, counters 0, mc_timeout 0, step edge register 0.
REQ-019 rst during WAIT or branch flush aborts it; the next cycle behaves as if from reset.

Configuration
REQ-020 Macro HAZARD_DEBUG_EN defined: ports debug_en (in, 1) and debug_step (in, 1) exist.
REQ-021 With HAZARD_DEBUG_EN: debug_en & ~(rising edge of registered debug_step) -> stage_en=0; counters and FSM frozen.
REQ-022 Without HAZARD_DEBUG_EN: no debug ports, no debug hold, no extra flops.

Verification
REQ-023 rs_addr=5, rs_used=1, fwd_addr stage1=5, fwd_wen=2'b01, not load -> rs_fwd_sel=1, stage_en=5'b11111.
REQ-024 Same with fwd_is_load[0]=1 -> rs_fwd_sel=0, stage_en=5'b11100, stage_rst=5'b00100; one cycle later with load in stage 2 -> sel=2, no stall.
REQ-025 id_is_branch for 1 cycle, BRANCH_PENALTY=3 -> stage_rst[1]=1 for exactly 3 consecutive cycles.
REQ-026 mc_start at cycle 0, mc_done at cycle 5 -> stage_en[2:0]=0 cycles 0-4, released cycle 5; mc_done never with MC_TIMEOUT=8 -> mc_timeout=1 after 8 WAIT cycles, pipeline released.
REQ-027 rst asserted mid-WAIT and mid-flush -> next cycle stage_en=5'b11111, stage_rst=0, mc_timeout=0.
